// File: rtl/scemi_pipe_pkg.sv
// Shared types and helpers for the SCE-MI input pipe put batcher.
package scemi_pipe_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scemi_in_pipe_put_batcher_if.sv
// Put-side and link-side signals of the batcher; slave is the batcher, master the environment.
interface scemi_in_pipe_put_batcher_if
  import scemi_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                    PUT_EN;
  logic [WIDTH-1:0]        PUT_DATA;
  logic                    PUT_EOM;
  logic                    PUT_RDY;
  logic                    FLUSH;
  logic [WIDTH-1:0]        LINK_DATA;
  logic                    LINK_EOM;
  logic                    LINK_VALID;
  logic                    LINK_ACK;
  logic [clog2(DEPTH):0]   COUNT;

  modport slave (
    input  PUT_EN, PUT_DATA, PUT_EOM, FLUSH, LINK_ACK,
    output PUT_RDY, LINK_DATA, LINK_EOM, LINK_VALID, COUNT
  );

  modport master (
    output PUT_EN, PUT_DATA, PUT_EOM, FLUSH, LINK_ACK,
    input  PUT_RDY, LINK_DATA, LINK_EOM, LINK_VALID, COUNT
  );
endinterface

// File: rtl/scemi_pipe_fifo.sv
// Circular buffer of DEPTH entries with registered occupancy; storage is not reset.
module scemi_pipe_fifo
  import scemi_pipe_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/scemi_in_pipe_put_batcher.sv
// Buffers put elements and releases them to the link in bursts of BATCH, at EOM, or on flush.
//   state  | meaning
//   IDLE   | holding elements, link not offered
//   STREAM | offering head element, counting burst transfers
module scemi_in_pipe_put_batcher
  import scemi_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int BATCH = 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  scemi_in_pipe_put_batcher_if.slave  bus
);
  localparam int            CW      = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BATCH_C = CW'(BATCH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] eomcnt_q, eomcnt_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          flush_q, flush_d;
  logic [CW-1:0] count_q, count_nxt;
  logic [WIDTH:0] head;
  logic          put_rdy, link_valid, push, pop;

  scemi_pipe_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RST_N),
    .wr_en   (push),
    .wr_data ({bus.PUT_EOM, bus.PUT_DATA}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count_q)
  );

  always_comb begin
    put_rdy    = (count_q != DEPTH_C);
    push       = bus.PUT_EN & put_rdy;
    link_valid = (state_q == STREAM) && (count_q != '0);
    pop        = link_valid & bus.LINK_ACK;
    count_nxt  = count_q + CW'(push) - CW'(pop);
    eomcnt_d   = eomcnt_q + CW'(push & bus.PUT_EOM) - CW'(pop & head[WIDTH]);

    flush_d = flush_q;
    if (bus.FLUSH && (count_q != '0)) flush_d = 1'b1;
    if (count_nxt == '0) flush_d = 1'b0;

    state_d = state_q;
    burst_d = burst_q;
    // Decisions use post-edge occupancy so a new element is offered the very next cycle.
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if ((count_nxt != '0) &&
            ((count_nxt >= BATCH_C) || (eomcnt_d != '0) || flush_d))
          state_d = STREAM;
      end
      STREAM: begin
        if (pop) begin
          if (burst_q != BATCH_C) burst_d = burst_q + ONE;
          if (head[WIDTH] || (count_nxt == '0) ||
              (!flush_d && ((burst_q + ONE) >= BATCH_C))) begin
            state_d = IDLE;
            burst_d = '0;
          end
        end else if (count_q == '0) begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      state_q  <= IDLE;
      eomcnt_q <= '0;
      burst_q  <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      eomcnt_q <= eomcnt_d;
      burst_q  <= burst_d;
      flush_q  <= flush_d;
    end
  end

  // Head is gated so unreset storage never reaches the link while not offered.
  assign bus.PUT_RDY    = put_rdy;
  assign bus.LINK_VALID = link_valid;
  assign bus.LINK_DATA  = link_valid ? head[WIDTH-1:0] : '0;
  assign bus.LINK_EOM   = link_valid & head[WIDTH];
  assign bus.COUNT      = count_q;

endmodule

// File: tb/tb_scemi_in_pipe_put_batcher.sv
// Scoreboard bench: accepted puts queue expected link elements; a negedge monitor checks every transfer.
module tb_scemi_in_pipe_put_batcher;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  scemi_in_pipe_put_batcher_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

  scemi_in_pipe_put_batcher #(.WIDTH(8), .DEPTH(DEPTH), .BATCH(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];
  int pend_push = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge; return just after the falling edge.
  task automatic step(input logic pen, input logic [7:0] d, input logic e,
                      input logic fl, input logic ack);
    @(posedge CLK);
    #1;
    pend_push = 0;
    bus.PUT_EN   = pen;
    bus.PUT_DATA = d;
    bus.PUT_EOM  = e;
    bus.FLUSH    = fl;
    bus.LINK_ACK = ack;
    if (pen && !RST_N && (exp_q.size() < DEPTH)) begin
      exp_q.push_back({e, d});
      pend_push = 1;
    end
    #5;
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 8'h00, 1'b0, 1'b0, ack);
  endtask

  task automatic drain();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1'b1);
    chk("drain_empty", exp_q.size(), 0);
    idle(1'b1);
    chk("idle_after_drain", bus.LINK_VALID, 1'b0);
  endtask

  // Monitor
  int         mon_occ;
  logic       hold_valid = 1'b0;
  logic [8:0] hold_elem;
  logic [8:0] mon_e;
  always @(negedge CLK) begin
    if (!RST_N) begin
      mon_occ = exp_q.size() - pend_push;
      chk("count", bus.COUNT, mon_occ);
      chk("put_rdy", bus.PUT_RDY, (mon_occ != DEPTH));
      if (bus.LINK_VALID && hold_valid)
        chk("link_stable", {bus.LINK_EOM, bus.LINK_DATA}, hold_elem);
      if (bus.LINK_VALID && bus.LINK_ACK) begin
        if (mon_occ == 0) begin
          chk("transfer_when_empty", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("link_data", bus.LINK_DATA, mon_e[7:0]);
          chk("link_eom", bus.LINK_EOM, mon_e[8]);
        end
      end
      hold_valid = bus.LINK_VALID && !bus.LINK_ACK;
      hold_elem  = {bus.LINK_EOM, bus.LINK_DATA};
    end else begin
      hold_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PUT_EN = 1'b0; bus.PUT_DATA = '0; bus.PUT_EOM = 1'b0;
    bus.FLUSH = 1'b0; bus.LINK_ACK = 1'b0;
    #1 RST_N = 1'b1;
    #2;
    chk("rst_put_rdy", bus.PUT_RDY, 1'b1);
    chk("rst_valid", bus.LINK_VALID, 1'b0);
    chk("rst_eom", bus.LINK_EOM, 1'b0);
    chk("rst_data", bus.LINK_DATA, 8'h00);
    chk("rst_count", bus.COUNT, 0);
    @(negedge CLK); #1 RST_N = 1'b0;

    // Two-element batch streams back to back
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    chk("b1_valid_low", bus.LINK_VALID, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("b2_valid_low", bus.LINK_VALID, 1'b0);
    idle(1'b1);
    chk("b_first_valid", bus.LINK_VALID, 1'b1);
    chk("b_first_data", bus.LINK_DATA, 8'h11);
    idle(1'b1);
    chk("b_second_valid", bus.LINK_VALID, 1'b1);
    chk("b_second_data", bus.LINK_DATA, 8'h22);
    idle(1'b1);
    chk("b_done_valid", bus.LINK_VALID, 1'b0);
    chk("b_done_count", bus.COUNT, 0);

    // Lone EOM element goes out immediately
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("eom_valid", bus.LINK_VALID, 1'b1);
    chk("eom_flag", bus.LINK_EOM, 1'b1);
    chk("eom_data", bus.LINK_DATA, 8'h33);
    idle(1'b1);
    chk("eom_after", bus.LINK_VALID, 1'b0);

    // Fill while stalled, extra put ignored, one ack frees a slot
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("full_count", bus.COUNT, 4);
    chk("full_rdy", bus.PUT_RDY, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("afterack_count", bus.COUNT, 3);
    chk("afterack_rdy", bus.PUT_RDY, 1'b1);
    drain();

    // Partial batch waits until flushed
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      chk("hold_valid_low", bus.LINK_VALID, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("flush_cycle_valid", bus.LINK_VALID, 1'b0);
    idle(1'b1);
    chk("flush_valid", bus.LINK_VALID, 1'b1);
    chk("flush_data", bus.LINK_DATA, 8'h44);
    idle(1'b1);
    chk("flush_done", bus.COUNT, 0);

    // Flush while empty leaves nothing pending
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("empty_flush_no_effect", bus.LINK_VALID, 1'b0);
    end
    drain();

    // Put and transfer in the same cycle keeps occupancy
    step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("simul_pre_valid", bus.LINK_VALID, 1'b1);
    step(1'b1, 8'h73, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("simul_count", bus.COUNT, 2);
    drain();

    // Reset mid-burst discards held elements
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_rst_count", bus.COUNT, 3);
    RST_N = 1'b1;
    #1;
    chk("mid_rst_valid", bus.LINK_VALID, 1'b0);
    chk("mid_rst_count", bus.COUNT, 0);
    chk("mid_rst_rdy", bus.PUT_RDY, 1'b1);
    chk("mid_rst_data", bus.LINK_DATA, 8'h00);
    exp_q.delete();
    pend_push = 0;
    bus.PUT_EN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1 RST_N = 1'b0;
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("post_rst_data", bus.LINK_DATA, 8'h5A);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 3) != 0), 8'($urandom),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0),
           logic'($urandom_range(0, 3) != 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
